yc_sync_inserter: RTL

Output stage placed directly after the luma/chroma generator on the analog (Analogizer) video path. It takes the packed `{C, Y, 8'd0}` word and the delayed syncs from that generator and produces DAC-ready signals:

- luma with a sync tip, a blanking level and a scaled active range;
- chroma forced to the zero-chroma reference during sync;
- a saturated composite (CVBS) sum;
- a blank flag.

A small line-phase state machine, driven by csync/vsync, decides which level each sample carries.

---
 rtl/yc_pkg.sv | 22 ++
 rtl/yc_sat_add.sv | 25 ++
 rtl/yc_sync_inserter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/yc_pkg.sv
// Shared types and helpers for the Y/C sync inserter output stage.
package yc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        BPORCH,
        ACTIVE
    } line_state_t;

    localparam logic [7:0] C_ZERO = 8'd128;

    function automatic logic [7:0] sat_u8(input logic signed [9:0] v);
        if (v < 10'sd0)
            return 8'd0;
        else if (v > 10'sd255)
            return 8'd255;
        else
            return v[7:0];
    endfunction

endpackage

// File: rtl/yc_sat_add.sv
// Registered signed add of two 10-bit operands, clamped to an unsigned byte.
module yc_sat_add
    import yc_pkg::*;
#(
    parameter logic [7:0] RESET_VALUE = 8'd0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic signed [9:0] a,
    input  logic signed [9:0] b,
    output logic [7:0]        sum_o
);

    logic signed [9:0] sum;

    assign sum = a + b;

    always_ff @(posedge clk) begin
        if (!reset_n)
            sum_o <= RESET_VALUE;
        else
            sum_o <= sat_u8(sum);
    end

endmodule

// File: rtl/yc_sync_inserter.sv
// Analog video output stage: inserts sync tip and blanking into luma, zeroes
// chroma during sync and forms a clamped composite sum, with 3 clocks of latency.
module yc_sync_inserter
    import yc_pkg::*;
#(
    parameter logic [7:0]  SYNC_LEVEL  = 8'd0,
    parameter logic [7:0]  BLANK_LEVEL = 8'd64,
    parameter logic [8:0]  LUMA_GAIN   = 9'd192,
    parameter logic [11:0] BP_CYCLES   = 12'd200
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [23:0] din,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic        csync_i,
    output logic [7:0]  y_o,
    output logic [7:0]  c_o,
    output logic [7:0]  cvbs_o,
    output logic        blank_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        csync_o
);

    // Stage 1 state: line phase and data registered together for the same sample
    line_state_t state;
    logic [11:0] bp_cnt;
    logic        vblank;
    logic        enter_active;
    logic [7:0]  y1;
    logic [7:0]  c1;
    logic        hs1, vs1, cs1;
    logic        unused_din;

    // Stage 2
    logic [16:0] prod;
    logic        active_vid;
    logic [7:0]  base2;
    logic [8:0]  scaled2;
    logic [7:0]  c2;
    logic        blank2;
    logic        hs2, vs2, cs2;

    // Stage 3
    logic signed [9:0] luma_a;
    logic signed [9:0] luma_b;
    logic signed [9:0] luma_sum;
    logic [7:0]        luma_sat;
    logic signed [9:0] cvbs_a;
    logic signed [9:0] chroma_off;

    assign unused_din = ^din[7:0];

    assign enter_active = !csync_i &&
                          ((state == SYNC   && BP_CYCLES == 12'd0) ||
                           (state == BPORCH && bp_cnt == BP_CYCLES - 12'd1));

    // A high csync sample always forces SYNC, aborting any back porch in progress
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            bp_cnt <= 12'd0;
            vblank <= 1'b1;
        end else begin
            if (csync_i) begin
                state <= SYNC;
            end else begin
                case (state)
                    SYNC: begin
                        bp_cnt <= 12'd0;
                        state  <= enter_active ? ACTIVE : BPORCH;
                    end
                    BPORCH: begin
                        if (enter_active)
                            state <= ACTIVE;
                        else
                            bp_cnt <= bp_cnt + 12'd1;
                    end
                    default: state <= state;
                endcase
            end

            if (vsync_i)
                vblank <= 1'b1;
            else if (enter_active)
                vblank <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            y1  <= 8'd0;
            c1  <= C_ZERO;
            hs1 <= 1'b0;
            vs1 <= 1'b0;
            cs1 <= 1'b0;
        end else begin
            y1  <= din[15:8];
            c1  <= din[23:16];
            hs1 <= hsync_i;
            vs1 <= vsync_i;
            cs1 <= csync_i;
        end
    end

    assign prod       = {9'd0, y1} * {8'd0, LUMA_GAIN};
    assign active_vid = (state == ACTIVE) && !vblank;

    // Luma is kept as base level plus scaled video so stage 3 can saturate it
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            base2   <= BLANK_LEVEL;
            scaled2 <= 9'd0;
            c2      <= C_ZERO;
            blank2  <= 1'b1;
            hs2     <= 1'b0;
            vs2     <= 1'b0;
            cs2     <= 1'b0;
        end else begin
            base2   <= (state == SYNC) ? SYNC_LEVEL : BLANK_LEVEL;
            scaled2 <= active_vid ? prod[16:8] : 9'd0;
            c2      <= (state == SYNC || state == IDLE) ? C_ZERO : c1;
            blank2  <= !active_vid;
            hs2     <= hs1;
            vs2     <= vs1;
            cs2     <= cs1;
        end
    end

    // BLANK_LEVEL plus the largest scaled luma must stay below 512 for the 10-bit sum
    assign luma_a     = signed'({2'b00, base2});
    assign luma_b     = signed'({1'b0, scaled2});
    assign luma_sum   = luma_a + luma_b;
    assign luma_sat   = sat_u8(luma_sum);
    assign cvbs_a     = signed'({2'b00, luma_sat});
    assign chroma_off = signed'({2'b00, c2}) - 10'sd128;

    yc_sat_add #(
        .RESET_VALUE(BLANK_LEVEL)
    ) u_luma_add (
        .clk    (clk),
        .reset_n(reset_n),
        .a      (luma_a),
        .b      (luma_b),
        .sum_o  (y_o)
    );

    yc_sat_add #(
        .RESET_VALUE(BLANK_LEVEL)
    ) u_cvbs_add (
        .clk    (clk),
        .reset_n(reset_n),
        .a      (cvbs_a),
        .b      (chroma_off),
        .sum_o  (cvbs_o)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            c_o     <= C_ZERO;
            blank_o <= 1'b1;
            hsync_o <= 1'b0;
            vsync_o <= 1'b0;
            csync_o <= 1'b0;
        end else begin
            c_o     <= c2;
            blank_o <= blank2;
            hsync_o <= hs2;
            vsync_o <= vs2;
            csync_o <= cs2;
        end
    end

endmodule
